tanh4_act_requant: RTL and testbench



---
 rtl/tanh4_act_requant.sv | 122 ++++++++++++
 tb/tb_tanh4_act_requant.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tanh4_act_requant.sv
// Round/shift/saturate a wide signed sample down to a 4-bit tanh operand.
// The result goes through a 2-entry skid FIFO, and a sticky counter counts the saturated samples.
module tanh4_act_requant #(
  parameter int IN_W      = 12,
  parameter int SHIFT     = 4,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_data,
  output logic [SAT_CNT_W-1:0] sat_count,
  input  logic                 clr_sat
);

  localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'(7);
  localparam logic signed [IN_W:0] MIN_V = (IN_W+1)'(-8);

  logic signed [IN_W:0]   w_ext;
  logic signed [IN_W:0]   w_r;
  logic                   w_sat_hi;
  logic                   w_sat_lo;
  logic [3:0]             w_code;
  logic                   w_acc;
  logic                   w_emit;
  logic [1:0]             w_count_nxt;
  logic [3:0]             w_head_nxt;
  logic [3:0]             w_tail_nxt;

  logic [1:0]             r_count;
  logic [3:0]             r_head;
  logic [3:0]             r_tail;
  logic                   r_in_ready;
  logic [SAT_CNT_W-1:0]   r_sat_count;

  // One guard bit on top of IN_W, so adding the rounding constant can never overflow.
  assign w_ext = $signed({in_data[IN_W-1], in_data});

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT - 1);
      assign w_r = (w_ext + HALF) >>> SHIFT;
    end else begin : g_pass
      assign w_r = w_ext;
    end
  endgenerate

  assign w_sat_hi = (w_r > MAX_V);
  assign w_sat_lo = (w_r < MIN_V);
  assign w_code   = w_sat_hi ? 4'h7 : (w_sat_lo ? 4'h8 : w_r[3:0]);

  assign w_acc  = in_valid & r_in_ready;
  assign w_emit = (r_count != 2'd0) & out_ready;

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves a value unassigned and no latch is inferred.
    w_count_nxt = r_count;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    case (r_count)
      2'd0: begin
        if (w_acc) begin
          w_head_nxt  = w_code;
          w_count_nxt = 2'd1;
        end
      end
      2'd1: begin
        if (w_acc && w_emit) begin
          w_head_nxt = w_code;
        end else if (w_acc) begin
          w_tail_nxt  = w_code;
          w_count_nxt = 2'd2;
        end else if (w_emit) begin
          w_count_nxt = 2'd0;
        end
      end
      default: begin
        if (w_emit) begin
          w_head_nxt  = r_tail;
          w_count_nxt = 2'd1;
        end
      end
    endcase
  end

  // in_ready is registered from the next occupancy, so out_ready has no combinational path to it.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every flop samples its pre-edge value.
    if (rst) begin
      r_count    <= 2'd0;
      r_head     <= 4'h0;
      r_in_ready <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_head     <= w_head_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
    end
  end

  // NOTE: the tail entry is storage qualified by r_count, so it needs no reset.
  always_ff @(posedge clk) begin
    r_tail <= w_tail_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_sat) begin
      r_sat_count <= '0;
    end else if (w_acc && (w_sat_hi || w_sat_lo) && (r_sat_count != '1)) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_head;
  assign sat_count = r_sat_count;

endmodule

// File: tb/tb_tanh4_act_requant.sv
// Self-checking bench for tanh4_act_requant: directed vectors, backpressure/reset sequences,
// and random traffic checked against a queue-based reference model.
module tb_tanh4_act_requant;

  localparam int IN_W    = 12;
  localparam int SHIFT   = 4;
  localparam int SAT_W   = 4;
  localparam int SAT_MAX = (1 << SAT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_data;
  logic [SAT_W-1:0] sat_count;
  logic             clr_sat;

  tanh4_act_requant #(.IN_W(IN_W), .SHIFT(SHIFT), .SAT_CNT_W(SAT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_count (sat_count),
    .clr_sat   (clr_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  logic [3:0] m_q[$];
  int         m_sat;
  bit         m_rdy;
  logic [3:0] dut_log[$];

  typedef struct {
    int         din;
    logic [3:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: floor((x + 2^(SHIFT-1)) / 2^SHIFT), then clamp to [-8, 7].
  function automatic void ref_code(input logic [IN_W-1:0] d, output logic [3:0] code, output bit sat);
    int x, div, half, r, q;
    x    = $signed(d);
    div  = 1 << SHIFT;
    half = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
    r    = x + half;
    if (r >= 0) q = r / div;
    else        q = -((-r + div - 1) / div);
    sat = (q > 7) || (q < -8);
    if (q > 7)       code = 4'h7;
    else if (q < -8) code = 4'h8;
    else             code = q[3:0];
  endfunction

  task automatic set_in(input bit v, input int data, input bit ordy, input bit clr);
    in_valid  = v;
    in_data   = data[IN_W-1:0];
    out_ready = ordy;
    clr_sat   = clr;
  endtask

  // Called at a negedge with inputs already driven. Checks outputs against the model,
  // advances the model across the coming posedge, then returns at the next negedge.
  task automatic step();
    bit acc, emit, sat;
    logic [3:0] code;
    check("in_ready", in_ready, m_rdy);
    check("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("out_data", out_data, m_q[0]);
    check("sat_count", sat_count, m_sat);
    if (out_valid && out_ready) dut_log.push_back(out_data);
    acc  = in_valid && m_rdy;
    emit = (m_q.size() != 0) && out_ready;
    ref_code(in_data, code, sat);
    if (rst) begin
      m_q.delete();
      m_sat = 0;
      m_rdy = 1'b0;
    end else begin
      if (emit) void'(m_q.pop_front());
      if (acc) m_q.push_back(code);
      if (clr_sat) m_sat = 0;
      else if (acc && sat && m_sat < SAT_MAX) m_sat++;
      m_rdy = (m_q.size() < 2);
    end
    @(negedge clk);
  endtask

  vec_t vecs[9];
  int   bp_data[3];

  initial begin
    vecs[0] = '{53,   4'h3};
    vecs[1] = '{-24,  4'hF};
    vecs[2] = '{8,    4'h1};
    vecs[3] = '{-8,   4'h0};
    vecs[4] = '{7,    4'h0};
    vecs[5] = '{-9,   4'hF};
    vecs[6] = '{2032, 4'h7};
    vecs[7] = '{-200, 4'h8};
    vecs[8] = '{120,  4'h7};
    bp_data = '{16, 32, 48};

    rst = 1'b1;
    set_in(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    m_q.delete();
    m_sat = 0;
    m_rdy = 1'b0;
    check("reset_out_data", out_data, 4'h0);
    step();

    rst = 1'b0;
    step();
    check("ready_after_reset", in_ready, 1'b1);

    // Directed vectors, out_ready held high: each result visible one cycle after accept.
    for (int i = 0; i < 9; i++) begin
      set_in(1, vecs[i].din, 1, 0);
      step();
      check("vec_valid", out_valid, 1'b1);
      check($sformatf("vec_%0d", vecs[i].din), out_data, vecs[i].exp);
      if (i == 1) check("no_sat_yet", sat_count, 0);
    end
    check("sat_count_3", sat_count, 3);

    set_in(1, 2032, 1, 1);
    step();
    check("clr_priority", sat_count, 0);

    set_in(0, 0, 1, 0);
    step();
    step();

    // Backpressure: two accepts fill the FIFO, the third waits for space.
    dut_log.delete();
    begin
      int idx = 0;
      for (int c = 0; c < 10; c++) begin
        bit a;
        set_in(idx < 3, (idx < 3) ? bp_data[idx] : 0, c >= 4, 0);
        a = in_valid && m_rdy;
        step();
        if (a) idx++;
        if (c == 2 || c == 3) begin
          check("bp_in_ready_low", in_ready, 1'b0);
          check("bp_hold", out_data, 4'h1);
        end
      end
      check("bp_all_accepted", idx, 3);
    end
    check("bp_count", dut_log.size(), 3);
    if (dut_log.size() == 3) begin
      check("bp_order0", dut_log[0], 4'h1);
      check("bp_order1", dut_log[1], 4'h2);
      check("bp_order2", dut_log[2], 4'h3);
    end

    // Steady throughput at occupancy 1.
    dut_log.delete();
    for (int c = 0; c < 16; c++) begin
      set_in(1, c * 16, 1, 0);
      step();
      check("steady_ready", in_ready, 1'b1);
    end
    check("steady_rate", dut_log.size(), 15);

    // Saturation counter holds at its maximum.
    set_in(0, 0, 1, 1);
    step();
    for (int c = 0; c < 20; c++) begin
      set_in(1, (c % 2) ? -2000 : 2000, 1, 0);
      step();
    end
    check("sat_sticky", sat_count, SAT_MAX);
    set_in(0, 0, 1, 1);
    step();
    check("sat_clear", sat_count, 0);

    // Reset with the FIFO full: buffered samples must never appear.
    set_in(1, 100, 0, 0);
    step();
    step();
    step();
    check("full_before_rst", in_ready, 1'b0);
    rst = 1'b1;
    set_in(0, 0, 1, 0);
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_sat", sat_count, 0);
    rst = 1'b0;
    dut_log.delete();
    for (int c = 0; c < 4; c++) step();
    check("no_stale_emit", dut_log.size(), 0);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 1), int'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 31) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
